// File: rtl/acknak_latency_timer_mc.sv
// Per-channel AckNak latency timers on a shared prescaled tick; expiry raises a level request plus a one-cycle pulse.
// Latency: tlp_accepted -> running is 1 cycle; all outputs come straight from registers and no backpressure exists.
module acknak_latency_timer_mc #(
   parameter int NUM_CH     = 4,
   parameter int TIMER_W    = 16,
   parameter int PRESCALE_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dl_inactive,
   input  logic [TIMER_W-1:0]          threshold,
   input  logic [PRESCALE_W-1:0]       prescale,
   input  logic [NUM_CH-1:0]           tlp_accepted,
   input  logic [NUM_CH-1:0]           ack_nak_sched,
   input  logic [NUM_CH-1:0]           all_acked,
   output logic [NUM_CH*TIMER_W-1:0]   timer_value,
   output logic [NUM_CH-1:0]           running,
   output logic [NUM_CH-1:0]           ack_req,
   output logic [NUM_CH-1:0]           expire_pulse,
   output logic                        any_expired
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_EXPIRED = 2'd2
   } state_e;

   logic [PRESCALE_W-1:0]          presc_cnt_q, presc_cnt_d;
   logic                           tick;
   state_e                         state_q [NUM_CH];
   state_e                         state_d [NUM_CH];
   logic [NUM_CH-1:0][TIMER_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]              pulse_q, pulse_d;

   function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
      return (&v) ? v : v + TIMER_W'(1);
   endfunction

   // A prescale lowered below the running count ticks at once via >=.
   always_comb begin
      tick = !dl_inactive && (presc_cnt_q >= prescale);
      if (dl_inactive || tick) begin
         presc_cnt_d = '0;
      end else begin
         presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt_q <= '0;
         cnt_q       <= '0;
         pulse_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= S_IDLE;
         end
      end else begin
         presc_cnt_q <= presc_cnt_d;
         cnt_q       <= cnt_d;
         pulse_q     <= pulse_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         pulse_d[i] = 1'b0;
         if (dl_inactive) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
         end else if (ack_nak_sched[i] || all_acked[i]) begin
            // A TLP arriving with the Ack is not covered by it, so timing restarts for that TLP.
            state_d[i] = tlp_accepted[i] ? S_RUN : S_IDLE;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               S_IDLE: begin
                  if (tlp_accepted[i]) begin
                     state_d[i] = S_RUN;
                     cnt_d[i]   = '0;
                  end
               end
               S_RUN: begin
                  if (tick) begin
                     cnt_d[i] = sat_inc(cnt_q[i]);
                     if ((threshold != '0) && (sat_inc(cnt_q[i]) >= threshold)) begin
                        state_d[i] = S_EXPIRED;
                        pulse_d[i] = 1'b1;
                     end
                  end
               end
               S_EXPIRED: ;
               default: begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      running = '0;
      ack_req = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         running[i] = (state_q[i] == S_RUN);
         ack_req[i] = (state_q[i] == S_EXPIRED);
      end
   end

   assign timer_value  = cnt_q;
   assign expire_pulse = pulse_q;
   assign any_expired  = |ack_req;

endmodule

// File: tb/tb_acknak_latency_timer_mc.sv
// Directed bench for acknak_latency_timer_mc (4 channels, 4-bit timers so saturation is reachable).
module tb_acknak_latency_timer_mc;

   localparam int NUM_CH     = 4;
   localparam int TIMER_W    = 4;
   localparam int PRESCALE_W = 8;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      dl_inactive;
   logic [TIMER_W-1:0]        threshold;
   logic [PRESCALE_W-1:0]     prescale;
   logic [NUM_CH-1:0]         tlp_accepted;
   logic [NUM_CH-1:0]         ack_nak_sched;
   logic [NUM_CH-1:0]         all_acked;
   logic [NUM_CH*TIMER_W-1:0] timer_value;
   logic [NUM_CH-1:0]         running;
   logic [NUM_CH-1:0]         ack_req;
   logic [NUM_CH-1:0]         expire_pulse;
   logic                      any_expired;

   int n_tests = 0;
   int n_fail  = 0;

   acknak_latency_timer_mc #(
      .NUM_CH     (NUM_CH),
      .TIMER_W    (TIMER_W),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .dl_inactive   (dl_inactive),
      .threshold     (threshold),
      .prescale      (prescale),
      .tlp_accepted  (tlp_accepted),
      .ack_nak_sched (ack_nak_sched),
      .all_acked     (all_acked),
      .timer_value   (timer_value),
      .running       (running),
      .ack_req       (ack_req),
      .expire_pulse  (expire_pulse),
      .any_expired   (any_expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tv"},  32'(timer_value), 32'h0);
      chk({tag, "_run"}, 32'(running), 32'h0);
      chk({tag, "_req"}, 32'(ack_req), 32'h0);
      chk({tag, "_pls"}, 32'(expire_pulse), 32'h0);
      chk({tag, "_any"}, 32'(any_expired), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      dl_inactive = 1'b0;
      threshold = 4'd5;
      prescale = 8'd0;
      tlp_accepted = '0;
      ack_nak_sched = '0;
      all_acked = '0;
      step(2);
      chk_all_zero("reset");
      rst = 1'b0;
      step(1);

      // Test 1: basic expiry, plus a second TLP while running must not restart.
      tlp_accepted[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      chk("t1_run", 32'(running), 32'h1);
      chk("t1_cnt0", 32'(timer_value), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         if (k == 2) tlp_accepted[0] = 1'b1;
         step(1);
         tlp_accepted[0] = 1'b0;
         chk($sformatf("t1_cnt%0d", k), 32'(timer_value), 32'(k));
         chk($sformatf("t1_pls%0d", k), 32'(expire_pulse), (k == 5) ? 32'h1 : 32'h0);
         chk($sformatf("t1_run%0d", k), 32'(running), (k == 5) ? 32'h0 : 32'h1);
      end
      chk("t1_req", 32'(ack_req), 32'h1);
      chk("t1_any", 32'(any_expired), 32'h1);
      step(1);
      chk("t1_hold_pls", 32'(expire_pulse), 32'h0);
      chk("t1_hold_req", 32'(ack_req), 32'h1);
      chk("t1_hold_cnt", 32'(timer_value), 32'h5);
      all_acked[0] = 1'b1;
      step(1);
      all_acked[0] = 1'b0;
      chk_all_zero("t1_clr");

      // Test 2a: Ack scheduled mid-run returns to IDLE.
      tlp_accepted[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      step(2);
      chk("t2a_cnt", 32'(timer_value), 32'h2);
      ack_nak_sched[0] = 1'b1;
      step(1);
      ack_nak_sched[0] = 1'b0;
      chk_all_zero("t2a_idle");

      // Test 2b: Ack together with a new TLP restarts the timer.
      tlp_accepted[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      step(2);
      tlp_accepted[0] = 1'b1;
      ack_nak_sched[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      ack_nak_sched[0] = 1'b0;
      chk("t2b_run", 32'(running), 32'h1);
      chk("t2b_cnt", 32'(timer_value), 32'h0);
      step(4);
      chk("t2b_cnt4", 32'(timer_value), 32'h4);
      chk("t2b_pls4", 32'(expire_pulse), 32'h0);
      step(1);
      chk("t2b_pls5", 32'(expire_pulse), 32'h1);
      chk("t2b_req5", 32'(ack_req), 32'h1);
      all_acked[0] = 1'b1;
      step(1);
      all_acked[0] = 1'b0;

      // Test 3: prescale 3, aligned by one dl_inactive cycle; tick lands every 4th cycle.
      prescale = 8'd3;
      threshold = 4'd2;
      dl_inactive = 1'b1;
      step(1);
      dl_inactive = 1'b0;
      tlp_accepted[1] = 1'b1;
      step(1);
      tlp_accepted[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic [31:0] exp_cnt;
         exp_cnt = (k < 3) ? 32'h0 : (k < 7) ? 32'h1 : 32'h2;
         chk($sformatf("t3_tv%0d", k), 32'(timer_value), exp_cnt << 4);
         chk($sformatf("t3_run%0d", k), 32'(running), (k < 7) ? 32'h2 : 32'h0);
         chk($sformatf("t3_pls%0d", k), 32'(expire_pulse), (k == 7) ? 32'h2 : 32'h0);
         if (k < 7) step(1);
      end
      chk("t3_req", 32'(ack_req), 32'h2);
      dl_inactive = 1'b1;
      step(1);
      dl_inactive = 1'b0;
      chk_all_zero("t3_clr");

      // Test 4: dl_inactive clears running channels and blocks a same-cycle start.
      prescale = 8'd0;
      threshold = 4'd0;
      tlp_accepted[2] = 1'b1;
      step(1);
      tlp_accepted[2] = 1'b0;
      step(3);
      tlp_accepted[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      step(3);
      chk("t4_tv", 32'(timer_value), 32'h0703);
      chk("t4_run", 32'(running), 32'h5);
      dl_inactive = 1'b1;
      tlp_accepted[3] = 1'b1;
      step(1);
      dl_inactive = 1'b0;
      tlp_accepted[3] = 1'b0;
      chk_all_zero("t4_clr");
      step(1);
      chk("t4_ch3", 32'(running), 32'h0);

      // Test 5: threshold 0 saturates without expiry; then raising threshold expires at once.
      tlp_accepted[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         chk($sformatf("t5_cnt%0d", k), 32'(timer_value), (k > 15) ? 32'hf : 32'(k));
         chk($sformatf("t5_pls%0d", k), 32'(expire_pulse), 32'h0);
      end
      chk("t5_run", 32'(running), 32'h1);
      threshold = 4'd10;
      step(1);
      chk("t5_pls", 32'(expire_pulse), 32'h1);
      chk("t5_req", 32'(ack_req), 32'h1);
      step(1);
      chk("t5_pls_once", 32'(expire_pulse), 32'h0);
      chk("t5_tv", 32'(timer_value), 32'hf);

      // Test 6: asynchronous reset mid-cycle from EXPIRED.
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("t6_rst");
      step(1);
      #3;
      rst = 1'b0;
      threshold = 4'd5;
      tlp_accepted[0] = 1'b1;
      step(1);
      tlp_accepted[0] = 1'b0;
      chk("t6_run", 32'(running), 32'h1);
      chk("t6_cnt0", 32'(timer_value), 32'h0);
      step(1);
      chk("t6_cnt1", 32'(timer_value), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acknak_latency_timer_mc.md
Name: acknak_latency_timer_mc

Overview:
Multi-channel AckNak latency timer for the flit-mode data link layer receive path.
- Keeps one independent timer per receive channel.
- Each timer measures time from the first unacknowledged good TLP until an Ack/Nak is scheduled or all TLPs are acknowledged.
- Uses a shared prescaled time base and a runtime-programmable threshold.
- On expiry, raises a per-channel level request to the Ack/Nak scheduler and a one-cycle event pulse.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
TIMER_W, 16, width of each channel's counter and of threshold
PRESCALE_W, 8, width of the prescale divider field

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dl_inactive  in  1  data link layer not active; global clear
threshold  in  TIMER_W  expiry count in ticks; 0 = expiry disabled
prescale  in  PRESCALE_W  tick every prescale+1 clk cycles
tlp_accepted  in  NUM_CH  good TLP received and forwarded (not nullified, LCRC OK), per channel
ack_nak_sched  in  NUM_CH  Ack/Nak scheduled for channel
all_acked  in  NUM_CH  no unacknowledged TLPs remain on channel
timer_value  out  NUM_CH*TIMER_W  channel i at [i*TIMER_W +: TIMER_W]
running  out  NUM_CH  channel in RUN
ack_req  out  NUM_CH  level; channel in EXPIRED
expire_pulse  out  NUM_CH  one-cycle pulse on entry to EXPIRED
any_expired  out  1  OR of ack_req

Behaviour:
- Reset (async, active-high): all outputs 0, all channels IDLE, prescale counter 0.
- Prescaler:
  - Shared counter presc_cnt.
  - tick = (presc_cnt >= prescale).
  - On tick presc_cnt <= 0, else presc_cnt+1.
  - dl_inactive forces presc_cnt to 0 and tick to 0.
  - Lowering prescale below presc_cnt produces an immediate tick.
- Per-channel FSM, states IDLE, RUN, EXPIRED. Priority each cycle, highest first:
  1. dl_inactive: -> IDLE, count 0. Overrides everything, including a same-cycle tlp_accepted.
  2. ack_nak_sched or all_acked:
     - With tlp_accepted the same cycle: -> RUN, count 0. The new TLP is not covered by the scheduled Ack.
     - Otherwise: -> IDLE, count 0.
  3. IDLE with tlp_accepted: -> RUN, count 0.
  4. RUN, tlp_accepted: ignored. No restart; the timer tracks the oldest unacknowledged TLP.
  5. RUN with tick: count <= count+1, saturating at all-ones.
     - If threshold != 0 and count+1 >= threshold: -> EXPIRED and expire_pulse=1 for exactly that following cycle.
  6. EXPIRED: count frozen, ack_req=1. Leaves only via rule 1 or 2.
- threshold is sampled every cycle.
  - Lowering threshold to <= count while in RUN expires on the next tick.
  - threshold=0 never expires; the count saturates.
- Outputs:
  - running = (state==RUN). ack_req = (state==EXPIRED). All registered; no combinational path from inputs.
  - timer_value reflects the registered count.
  - Latency tlp_accepted -> running=1 is 1 cycle.
- Channels are fully independent except for the shared tick, threshold and dl_inactive.
- Mid-operation reset returns every channel to IDLE asynchronously. No pulse is generated.

Test Plan:
1. NUM_CH=4, prescale=0, threshold=5; tlp_accepted[0] one cycle at T -> running[0]=1 from T+1; timer_value[0] = 1..5 at T+2..T+6; expire_pulse[0]=1 only in cycle T+6; ack_req[0] and any_expired held at 1; timer_value[0] stays 5.
2. Same setup, ack_nak_sched[0] at T+3 -> channel 0 IDLE at T+4, timer_value[0]=0, no pulse. Repeat with tlp_accepted[0] and ack_nak_sched[0] together at T+3 -> RUN, count 0 at T+4; expires at T+9.
3. prescale=3, threshold=2; tlp_accepted[1] with presc_cnt aligned so a tick occurs every 4 cycles -> count increments every 4th cycle; expire_pulse[1] on the 2nd tick after entry; channels 0, 2, 3 stay IDLE with all-zero outputs.
4. Channels 0 and 2 in RUN at counts 3 and 7; assert dl_inactive for one cycle together with tlp_accepted[3] -> all channels IDLE, counts 0, presc_cnt 0; channel 3 does not start.
5. threshold=0, prescale=0, TIMER_W=4; start channel 0 -> counts to 15 and saturates; no expire_pulse. Then write threshold=10 -> EXPIRED on the next cycle with a single pulse.
6. Channel 0 EXPIRED; assert rst asynchronously mid-cycle -> outputs 0 immediately. After deassert, tlp_accepted -> normal start with count 0.
